// File: rtl/discrete_mapper_sync_if.sv
// Cartridge-edge bus for the discrete mapper: CPU/PPU inputs in, upper flash/RAM address lines out.
// A bank write is committed on the falling edge of m2 when romsel and cpu_rw_in were both low while m2 was high.
interface discrete_mapper_sync_if;
  logic        m2;
  logic        romsel;
  logic        cpu_rw_in;
  logic [14:0] cpu_addr_in;
  logic [7:0]  cpu_data;
  logic [2:0]  ppu_addr_in;
  logic [8:0]  prg_addr_out;
  logic [7:0]  chr_addr_out;
  logic        ppu_ciram_a10;
  logic        bank_wr;

  modport master (
    output m2, romsel, cpu_rw_in, cpu_addr_in, cpu_data, ppu_addr_in,
    input  prg_addr_out, chr_addr_out, ppu_ciram_a10, bank_wr
  );

  modport slave (
    input  m2, romsel, cpu_rw_in, cpu_addr_in, cpu_data, ppu_addr_in,
    output prg_addr_out, chr_addr_out, ppu_ciram_a10, bank_wr
  );
endinterface

// File: rtl/discrete_mapper_sync.sv
// UxROM / mapper 180 / CNROM / AxROM discrete mapper with M2 sampled in the osc50 domain.
// One 8-bit bank register, committed on a synchronised M2 fall after a write to $8000-$FFFF.
module discrete_mapper_sync #(
  parameter int MODE          = 1,
  parameter int PRG_BANK_BITS = 3,
  parameter int CHR_BANK_BITS = 2,
  parameter int MIRROR        = 0
) (
  input  logic                   osc50,
  input  logic                   m2_rst,
  discrete_mapper_sync_if.slave  bus
);

  localparam logic [7:0] PRG_MASK      = 8'((9'd1 << PRG_BANK_BITS) - 9'd1);
  localparam logic [7:0] PRG_MASK_HALF = PRG_MASK >> 1;
  localparam logic [4:0] CHR_MASK      = 5'((6'd1 << CHR_BANK_BITS) - 6'd1);

  logic       m2_s1_q, m2_s1_d;
  logic       m2_s2_q, m2_s2_d;
  logic       m2_s3_q, m2_s3_d;
  logic [7:0] data_s1_q, data_s1_d;
  logic [7:0] data_s2_q, data_s2_d;
  logic       romsel_s1_q, romsel_s1_d;
  logic       romsel_s2_q, romsel_s2_d;
  logic       rw_s1_q, rw_s1_d;
  logic       rw_s2_q, rw_s2_d;
  logic [7:0] cap_data_q, cap_data_d;
  logic       cap_romsel_q, cap_romsel_d;
  logic       cap_rw_q, cap_rw_d;
  logic [7:0] bank_q, bank_d;
  logic       bank_wr_q, bank_wr_d;
  logic       m2_fall;

  assign m2_fall = !m2_s2_q && m2_s3_q;

  // Bus samples travel alongside m2 so the captured value is the one taken
  // on the same edge that last saw m2 high, never a post-fall sample.
  always_comb begin
    m2_s1_d      = bus.m2;
    m2_s2_d      = m2_s1_q;
    m2_s3_d      = m2_s2_q;
    data_s1_d    = bus.cpu_data;
    data_s2_d    = data_s1_q;
    romsel_s1_d  = bus.romsel;
    romsel_s2_d  = romsel_s1_q;
    rw_s1_d      = bus.cpu_rw_in;
    rw_s2_d      = rw_s1_q;
    cap_data_d   = cap_data_q;
    cap_romsel_d = cap_romsel_q;
    cap_rw_d     = cap_rw_q;
    bank_d       = bank_q;
    bank_wr_d    = 1'b0;
    if (m2_s2_q) begin
      cap_data_d   = data_s2_q;
      cap_romsel_d = romsel_s2_q;
      cap_rw_d     = rw_s2_q;
    end
    if (m2_fall && !cap_romsel_q && !cap_rw_q) begin
      bank_d    = cap_data_q;
      bank_wr_d = 1'b1;
    end
  end

  always_ff @(posedge osc50) begin
    if (m2_rst) begin
      m2_s1_q      <= 1'b0;
      m2_s2_q      <= 1'b0;
      m2_s3_q      <= 1'b0;
      data_s1_q    <= 8'h00;
      data_s2_q    <= 8'h00;
      romsel_s1_q  <= 1'b1;
      romsel_s2_q  <= 1'b1;
      rw_s1_q      <= 1'b1;
      rw_s2_q      <= 1'b1;
      cap_data_q   <= 8'h00;
      cap_romsel_q <= 1'b1;
      cap_rw_q     <= 1'b1;
      bank_q       <= 8'h00;
      bank_wr_q    <= 1'b0;
    end else begin
      m2_s1_q      <= m2_s1_d;
      m2_s2_q      <= m2_s2_d;
      m2_s3_q      <= m2_s3_d;
      data_s1_q    <= data_s1_d;
      data_s2_q    <= data_s2_d;
      romsel_s1_q  <= romsel_s1_d;
      romsel_s2_q  <= romsel_s2_d;
      rw_s1_q      <= rw_s1_d;
      rw_s2_q      <= rw_s2_d;
      cap_data_q   <= cap_data_d;
      cap_romsel_q <= cap_romsel_d;
      cap_rw_q     <= cap_rw_d;
      bank_q       <= bank_d;
      bank_wr_q    <= bank_wr_d;
    end
  end

  logic       a14;
  logic [7:0] pb;
  logic [7:0] prg_bank;
  logic [4:0] chr_bank;
  logic       ciram_a10;

  assign a14 = bus.cpu_addr_in[14];
  assign pb  = bank_q & PRG_MASK;

  always_comb begin
    prg_bank = 8'h00;
    case (MODE)
      0:       prg_bank = a14 ? PRG_MASK : pb;
      1:       prg_bank = a14 ? pb : 8'h00;
      2:       prg_bank = {7'b0, a14};
      3:       prg_bank = ((bank_q & PRG_MASK_HALF) << 1) | {7'b0, a14};
      default: prg_bank = 8'h00;
    endcase
  end

  always_comb begin
    chr_bank  = 5'd0;
    ciram_a10 = (MIRROR != 0) ? bus.ppu_addr_in[0] : bus.ppu_addr_in[1];
    if (MODE == 2) chr_bank = bank_q[4:0] & CHR_MASK;
    // AxROM selects a single nametable for the whole screen.
    if (MODE == 3) ciram_a10 = bank_q[4];
  end

  assign bus.prg_addr_out  = {prg_bank, bus.cpu_addr_in[13]};
  assign bus.chr_addr_out  = {chr_bank, bus.ppu_addr_in};
  assign bus.ppu_ciram_a10 = ciram_a10;
  assign bus.bank_wr       = bank_wr_q;

  logic unused_addr;
  assign unused_addr = ^bus.cpu_addr_in[12:0];

endmodule

// File: doc/discrete_mapper_sync.md
# discrete_mapper_sync

Parametrised discrete-logic cartridge mapper for the FC cartridge FPGA. It covers UxROM (mapper 2), reverse-UxROM (mapper 180), CNROM (mapper 3) and AxROM (mapper 7), selected at elaboration. CPU M2 is sampled in the `osc50` domain instead of being used as a clock. The block drives the upper PRG/CHR flash/RAM address lines and the CIRAM A10 mirroring line.

## Interface
Parameters:
- `MODE`, 1, mapping mode: 0 UxROM, 1 mapper180, 2 CNROM, 3 AxROM.
- `PRG_BANK_BITS`, 3, significant bank-register bits for PRG; 1..8.
- `CHR_BANK_BITS`, 2, significant bits for the CNROM 8 KiB CHR bank; 1..5.
- `MIRROR`, 0, fixed mirroring for modes 0–2: 1 vertical, 0 horizontal.

Ports:
- `osc50` in 1: system clock, 50 MHz.
- `m2_rst` in 1: synchronous, active-high reset.
- `m2` in 1: CPU M2, asynchronous to `osc50`.
- `romsel` in 1: /ROMSEL, active low.
- `cpu_rw_in` in 1: 1 read, 0 write.
- `cpu_addr_in` in 15: CPU A14..A0.
- `cpu_data` in 8: CPU data bus.
- `ppu_addr_in` in 3: PPU A12..A10.
- `prg_addr_out` out 9: PRG A21..A13.
- `chr_addr_out` out 8: CHR A17..A10.
- `ppu_ciram_a10` out 1: CIRAM A10.
- `bank_wr` out 1: one-cycle pulse when the bank register is committed.

## Operation
- M2 synchroniser: `m2_s1`→`m2_s2`→`m2_s3` flops. Fall is detected when `m2_s2`=0 and `m2_s3`=1.
- Capture stage: on every cycle with `m2_s2`=1, the block registers `cpu_data`, `romsel` and `cpu_rw_in` into `cap_*`.
- Commit: on a detected fall with `cap_romsel`=0 and `cap_rw`=0, `bank` (8 bits) takes `cap_data` and `bank_wr` pulses. All other falls are ignored.
- Any write to $8000–$FFFF commits. There is no address decode and no bus-conflict AND.
- Let `Pb` = `bank[PRG_BANK_BITS-1:0]`, zero-extended to 8 bits, and `ONES` = all ones in `PRG_BANK_BITS` bits, zero-extended.
- PRG 16 KiB bank field `prg_addr_out[21:14]`, by mode; `prg_addr_out[13]` always = `cpu_addr_in[13]`:
  - Mode 0: A14=0 → `Pb`; A14=1 → `ONES`.
  - Mode 1: A14=0 → 0; A14=1 → `Pb`.
  - Mode 2: {7'b0, A14}.
  - Mode 3: {`bank[PRG_BANK_BITS-2:0]`, A14}, zero-extended. If `PRG_BANK_BITS`=1, the field is {7'b0, A14}.
- CHR:
  - `chr_addr_out[12:10]` = `ppu_addr_in`.
  - `chr_addr_out[17:13]` = `bank[CHR_BANK_BITS-1:0]`, zero-extended, in mode 2; otherwise 0.
- Mirroring:
  - Modes 0–2: `ppu_ciram_a10` = `ppu_addr_in[10]` if `MIRROR`=1, else `ppu_addr_in[11]`.
  - Mode 3: `ppu_ciram_a10` = `bank[4]` (single-screen).
- Address outputs are combinational from `bank`, `cpu_addr_in` and `ppu_addr_in`. `bank` is the only state besides the synchroniser and the capture registers.

## Timing
- Reset (synchronous): `bank`=8'h00, synchroniser flops=0, `cap_romsel`=1, `cap_rw`=1, `bank_wr`=0.
- Output values during reset:
  - `prg_addr_out` follows the mode rules with `bank`=0. Mode 0 at A14=1 shows `ONES`; mode 1 shows bank 0 in both halves.
  - `chr_addr_out[17:13]`=0.
- Latency from M2 falling at the pin to `bank_wr`/new `bank`: 3–4 `osc50` cycles (60–80 ns). Address outputs change on the same edge that commits `bank`.
- Write data is taken from the last `osc50` sample with `m2_s2`=1. It is not sampled after the fall, so the CPU's short data hold after M2 falls is not required.
- Back-to-back CPU writes, one per M2 cycle (≥558 ns apart): each commits exactly once. The last write wins.
- M2 high-pulse shorter than one `osc50` period: may be missed. The result is either no commit or one commit, never two.
- Reset asserted mid-capture: capture state is cleared, so no commit occurs on the following fall. `bank`=0 in the first cycle after reset deasserts.
- Reset and a detected fall in the same cycle: reset wins.
- `bank` bits above the parameter widths are stored but never affect outputs, except `bank[4]` in mode 3.

## Test plan
- Reset, MODE=1, PRG_BANK_BITS=3: read $8000 → `prg_addr_out[21:14]`=0; write $05 to $C000; 4 cycles later read $C000 → `prg_addr_out[21:14]`=5, one `bank_wr` pulse.
- MODE=0: write $FA → `Pb`=2. $8000 → bank 2; $C000 → bank 7; `prg_addr_out[13]` tracks A13.
- MODE=2, CHR_BANK_BITS=2: write $03. PPU A12..A10=3'b101 → `chr_addr_out`=8'b000_11_101. PRG $C000 → bank 1.
- MODE=3: write $13 → $8000 maps to `prg_addr_out[21:14]`=8'h06, and `ppu_ciram_a10`=1 for all PPU addresses. Write $03 → `ppu_ciram_a10`=0.
- Write to $6000 (`romsel`=1), then a CPU read of $8000: no `bank_wr` pulse, `bank` unchanged. Then data changing 5 ns after M2 falls: the pre-fall value is committed.
- Reset pulse overlapping an M2 fall during a write cycle: no commit, `bank`=0.
